// File: rtl/data_port_pkg.sv
// data_port_pkg: shared definitions for the data_port block.
//   - access-type encodings as presented on accessType
//   - FSM state type
//   - is_io_addr: classifies the 2-bit IO selector slice of an address
//   - access_bytes: decodes accessType into a byte count (1/2/4, 0 for none)
package data_port_pkg;

  localparam logic [1:0] ACCESS_NONE = 2'b00;
  localparam logic [1:0] ACCESS_BYTE = 2'b01;
  localparam logic [1:0] ACCESS_HALF = 2'b10;
  localparam logic [1:0] ACCESS_WORD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StReadDone
  } state_e;

  // Caller passes addr[IO_SEL_HI:IO_SEL_HI-1].
  function automatic logic is_io_addr(input logic [1:0] ioSel);
    return ioSel == 2'b11;
  endfunction

  function automatic logic [2:0] access_bytes(input logic [1:0] accessType);
    logic [2:0] n;
    case (accessType)
      ACCESS_BYTE: n = 3'd1;
      ACCESS_HALF: n = 3'd2;
      ACCESS_WORD: n = 3'd4;
      default:     n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/data_port_line_buf.sv
// data_port_line_buf: one-entry, 4-byte read line buffer for data_port.
// Only instantiated when DATA_PORT_LINE_BUF_EN is defined.
// Ports:
//   clockIn, resetIn          clock, async active-high reset (invalidates)
//   lookupAddr, lookupBytes   candidate read request (start address, 1/2/4 bytes)
//   hit, hitData              request lies fully in the valid word; zero-extended data
//   fillEn, fillTag, fillData install a word (tag = word address addr[ADDR_WIDTH-1:2])
//   invEn, invAddr, invBytes  write request; drops the entry if any byte touches it
module data_port_line_buf #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic [ADDR_WIDTH-1:0] lookupAddr,
  input  logic [2:0]            lookupBytes,
  output logic                  hit,
  output logic [31:0]           hitData,
  input  logic                  fillEn,
  input  logic [ADDR_WIDTH-3:0] fillTag,
  input  logic [31:0]           fillData,
  input  logic                  invEn,
  input  logic [ADDR_WIDTH-1:0] invAddr,
  input  logic [2:0]            invBytes
);

  localparam int unsigned TagWidth = ADDR_WIDTH - 2;

  logic                validQ;
  logic [TagWidth-1:0] tagQ;
  logic [31:0]         dataQ;

  logic [3:0]          endOff;
  logic [31:0]         shifted;
  logic [2:0]          invLastOff;
  logic [TagWidth-1:0] invLastTag;
  logic                invTouch;

  always_comb begin
    // Hit only when every requested byte sits in the buffered word.
    endOff = {2'b00, lookupAddr[1:0]} + {1'b0, lookupBytes};
    hit    = validQ && (endOff <= 4'd4) && (tagQ == lookupAddr[ADDR_WIDTH-1:2]);

    shifted = dataQ >> {lookupAddr[1:0], 3'b000};
    case (lookupBytes)
      3'd1:    hitData = {24'h0, shifted[7:0]};
      3'd2:    hitData = {16'h0, shifted[15:0]};
      default: hitData = shifted;
    endcase

    // A write spans at most two words: the start word and the word of its last byte.
    invLastOff = {1'b0, invAddr[1:0]} + (invBytes - 3'd1);
    invLastTag = invAddr[ADDR_WIDTH-1:2] + TagWidth'(invLastOff[2]);
    invTouch   = invEn && validQ &&
                 ((tagQ == invAddr[ADDR_WIDTH-1:2]) || (tagQ == invLastTag));
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      validQ <= 1'b0;
      tagQ   <= '0;
      dataQ  <= '0;
    end else if (fillEn) begin
      validQ <= 1'b1;
      tagQ   <= fillTag;
      dataQ  <= fillData;
    end else if (invTouch) begin
      validQ <= 1'b0;
    end
  end

endmodule

// File: rtl/data_port.sv
// data_port: memory-side responder for the load/store buffer data interface.
// Serialises one byte/half/word request into byte transfers on a byte-wide
// RAM/IO port and returns a one-cycle completion pulse.
// Optional feature: define DATA_PORT_LINE_BUF_EN to add a one-entry word line
// buffer that answers fully-contained non-IO reads the cycle after the request.
// Ports:
//   clockIn, resetIn     clock, async active-high reset
//   clearIn              flush: aborts reads, ignored by writes
//   accessType           00 none, 01 byte, 10 half, 11 word (one-cycle request)
//   readWriteIn          1 read, 0 write
//   dataAddr, dataWrite  request start address and write data (low bytes)
//   dataValid, dataIn    read-complete pulse and zero-extended little-endian data
//   dataWriteSuc         write-complete pulse
//   memDin               read byte, valid the cycle after its address
//   ioBufferFull         IO write back-pressure
//   memAddr, memOut      byte address and write byte
//   memWrite             write strobe
module data_port
  import data_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IO_SEL_HI  = 17
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  clearIn,
  input  logic [1:0]            accessType,
  input  logic                  readWriteIn,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]           dataWrite,
  output logic                  dataValid,
  output logic [31:0]           dataIn,
  output logic                  dataWriteSuc,
  input  logic [7:0]            memDin,
  input  logic                  ioBufferFull,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [7:0]            memOut,
  output logic                  memWrite
);

  state_e                stateQ, stateD;
  logic [ADDR_WIDTH-1:0] memAddrQ, memAddrD;
  logic [31:0]           wDataQ, wDataD;
  logic [2:0]            numBytesQ, numBytesD;
  // Read: index of the byte whose address is on memAddr; reaches numBytesQ on the
  // cycle the last byte arrives. Write: index of the byte being written.
  logic [2:0]            issueQ, issueD;
  logic [31:0]           rdBufQ, rdBufD;
  logic [31:0]           dataInQ, dataInD;
  logic                  sucQ, sucD;

  logic                  request;
  logic [2:0]            reqBytes;
  logic                  stall;
  logic [1:0]            capIdx;
  logic                  lbHit;
  logic [31:0]           lbData;

  assign request  = accessType != ACCESS_NONE;
  assign reqBytes = access_bytes(accessType);
  assign stall    = is_io_addr(memAddrQ[IO_SEL_HI -: 2]) && ioBufferFull;
  assign capIdx   = issueQ[1:0] - 2'd1;

`ifdef DATA_PORT_LINE_BUF_EN
  logic lbHitRaw;
  logic lbFill;
  logic lbInv;

  // Only a memory-sourced aligned word fills: issueQ == 4 excludes buffer hits, and
  // memAddr ends on byte 3 only when the word started aligned.
  assign lbFill = (stateQ == StReadDone) && !clearIn && (numBytesQ == 3'd4) &&
                  (issueQ == 3'd4) && (memAddrQ[1:0] == 2'b11) &&
                  !is_io_addr(memAddrQ[IO_SEL_HI -: 2]);
  assign lbInv  = (stateQ == StIdle) && request && !readWriteIn;
  assign lbHit  = lbHitRaw && !is_io_addr(dataAddr[IO_SEL_HI -: 2]);

  data_port_line_buf #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_line_buf (
    .clockIn    (clockIn),
    .resetIn    (resetIn),
    .lookupAddr (dataAddr),
    .lookupBytes(reqBytes),
    .hit        (lbHitRaw),
    .hitData    (lbData),
    .fillEn     (lbFill),
    .fillTag    (memAddrQ[ADDR_WIDTH-1:2]),
    .fillData   (rdBufQ),
    .invEn      (lbInv),
    .invAddr    (dataAddr),
    .invBytes   (reqBytes)
  );
`else
  assign lbHit  = 1'b0;
  assign lbData = '0;
`endif

  always_comb begin
    stateD    = stateQ;
    memAddrD  = memAddrQ;
    wDataD    = wDataQ;
    numBytesD = numBytesQ;
    issueD    = issueQ;
    rdBufD    = rdBufQ;
    dataInD   = dataInQ;
    sucD      = 1'b0;

    unique case (stateQ)
      StIdle: begin
        // clearIn is deliberately not checked: a request here is already committed.
        if (request) begin
          wDataD    = dataWrite;
          numBytesD = reqBytes;
          issueD    = 3'd0;
          rdBufD    = '0;
          if (readWriteIn && lbHit) begin
            rdBufD = lbData;
            stateD = StReadDone;
          end else begin
            memAddrD = dataAddr;
            stateD   = readWriteIn ? StRead : StWrite;
          end
        end
      end
      StRead: begin
        if (clearIn) begin
          stateD = StIdle;
        end else begin
          if (issueQ != 3'd0) rdBufD[{capIdx, 3'b000} +: 8] = memDin;
          if (issueQ == numBytesQ) begin
            stateD = StReadDone;
          end else begin
            issueD = issueQ + 3'd1;
            // Hold the last byte address once it has been issued.
            if (issueQ + 3'd1 < numBytesQ) memAddrD = memAddrQ + ADDR_WIDTH'(1);
          end
        end
      end
      StWrite: begin
        if (!stall) begin
          if (issueQ == numBytesQ - 3'd1) begin
            stateD = StIdle;
            sucD   = 1'b1;
          end else begin
            issueD   = issueQ + 3'd1;
            memAddrD = memAddrQ + ADDR_WIDTH'(1);
          end
        end
      end
      StReadDone: begin
        stateD = StIdle;
        if (!clearIn) dataInD = rdBufQ;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      stateQ    <= StIdle;
      memAddrQ  <= '0;
      wDataQ    <= '0;
      numBytesQ <= '0;
      issueQ    <= '0;
      rdBufQ    <= '0;
      dataInQ   <= '0;
      sucQ      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      memAddrQ  <= memAddrD;
      wDataQ    <= wDataD;
      numBytesQ <= numBytesD;
      issueQ    <= issueD;
      rdBufQ    <= rdBufD;
      dataInQ   <= dataInD;
      sucQ      <= sucD;
    end
  end

  // A flush in the completion cycle suppresses both the pulse and the new data.
  assign dataValid    = (stateQ == StReadDone) && !clearIn;
  assign dataIn       = dataValid ? rdBufQ : dataInQ;
  assign dataWriteSuc = sucQ;
  assign memAddr      = memAddrQ;
  assign memWrite     = (stateQ == StWrite) && !stall;
  assign memOut       = (stateQ == StWrite) ? wDataQ[{issueQ[1:0], 3'b000} +: 8] : 8'h00;

  // Requests arriving while busy are dropped by the FSM.
  assert property (@(posedge clockIn) disable iff (resetIn)
    (accessType != ACCESS_NONE) |-> (stateQ == StIdle));

endmodule
